hazard_scheduler: RTL and testbench

- Pipeline sequencing controller for the 5-stage core. It shares the 18-bit register-file read ports and the writeback result between in-flight instructions.
- Keeps its own shadow of the E/M/W destination registers. From that shadow it generates decode-stage forward selects (ForwardAD/BD/CD), execute-stage forward selects, load-use stalls and branch/jump flushes.
- Sits beside decode_cycle. Its forward selects drive decode_cycle's RD1/RD2/RD4 muxes, and its stall/flush outputs gate the IF/ID and ID/EX registers.

---
 rtl/hazard_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_hazard_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: E/M/W destination shadow driving forward selects, load-use stalls and branch/jump flushes.
// Latency: all outputs combinational from D inputs + shadow; shadow advances one cycle behind D.
// Backpressure: load-use holds F/D and bubbles E for LOAD_STALL_CYCLES; flush overrides stall. HAZARD_PERF_CNT_EN adds counters.
module hazard_scheduler #(
    parameter int REG_AW             = 5,
    parameter int LOAD_STALL_CYCLES  = 1,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs4_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              load_d,
    input  logic              branch_taken_e,
    input  logic              jump_e,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              ForwardCD,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [1:0]        forward_ce,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        sched_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01
    } sched_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              load;
    } ex_ent_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } wb_ent_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL_CYCLES - 1);
    localparam bit         ZERO_HW  = (ZERO_REG_HARDWIRED != 0);

    ex_ent_t           ent_e;
    ex_ent_t           ent_m;
    wb_ent_t           ent_w;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rs4_e;
    sched_t            state;
    sched_t            state_n;
    logic [1:0]        cnt;
    logic [1:0]        cnt_n;
    logic              out_en;
    logic              flush;
    logic              detect;
    logic              stall_int;
    logic              flush_d_int;
    logic              flush_e_int;

    function automatic logic hit(input logic vld, input logic rw,
                                 input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] src);
        return vld & rw & (rd == src) & ~(ZERO_HW & (src == '0));
    endfunction

    // A load in M has no data yet, so it may only forward once it reaches W.
    function automatic logic [1:0] e_sel(input ex_ent_t m, input wb_ent_t w,
                                         input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit(m.vld, m.regwrite, m.rd, src) && !m.load) begin
            sel = 2'b10;
        end else if (hit(w.vld, w.regwrite, w.rd, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        flush       = branch_taken_e | jump_e;
        detect      = valid_d & ent_e.load &
                      (hit(ent_e.vld, ent_e.regwrite, ent_e.rd, rs1_d) |
                       hit(ent_e.vld, ent_e.regwrite, ent_e.rd, rs2_d) |
                       hit(ent_e.vld, ent_e.regwrite, ent_e.rd, rs4_d));
        state_n     = state;
        cnt_n       = cnt;
        stall_int   = 1'b0;
        flush_d_int = 1'b0;
        flush_e_int = 1'b0;
        // out_en keeps everything quiet through reset and the first cycle after release.
        if (out_en) begin
            if (flush) begin
                // Stalled consumer sits on the squashed path, so the stall is dropped.
                flush_d_int = 1'b1;
                flush_e_int = 1'b1;
                state_n     = RUN;
                cnt_n       = 2'd0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (detect) begin
                            stall_int   = 1'b1;
                            flush_e_int = 1'b1;
                            cnt_n       = CNT_INIT;
                            state_n     = (CNT_INIT != 2'd0) ? LSTALL : RUN;
                        end
                    end
                    LSTALL: begin
                        stall_int   = 1'b1;
                        flush_e_int = 1'b1;
                        cnt_n       = cnt - 2'd1;
                        state_n     = (cnt_n == 2'd0) ? RUN : LSTALL;
                    end
                    default: begin
                        state_n = RUN;
                        cnt_n   = 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            cnt    <= 2'd0;
            out_en <= 1'b0;
            ent_e  <= '0;
            ent_m  <= '0;
            ent_w  <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rs4_e  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            out_en <= 1'b1;
            ent_e  <= '{vld: valid_d & ~stall_int & ~flush_e_int, rd: rd_d,
                        regwrite: regwrite_d, load: load_d};
            rs1_e  <= rs1_d;
            rs2_e  <= rs2_d;
            rs4_e  <= rs4_d;
            ent_m  <= ent_e;
            ent_w  <= '{vld: ent_m.vld, rd: ent_m.rd, regwrite: ent_m.regwrite};
        end
    end

    assign stall_f     = stall_int;
    assign stall_d     = stall_int;
    assign flush_d     = flush_d_int;
    assign flush_e     = flush_e_int;
    assign sched_state = state;

    assign ForwardAD  = out_en & hit(ent_w.vld, ent_w.regwrite, ent_w.rd, rs1_d);
    assign ForwardBD  = out_en & hit(ent_w.vld, ent_w.regwrite, ent_w.rd, rs2_d);
    assign ForwardCD  = out_en & hit(ent_w.vld, ent_w.regwrite, ent_w.rd, rs4_d);
    assign forward_ae = out_en ? e_sel(ent_m, ent_w, rs1_e) : 2'b00;
    assign forward_be = out_en ? e_sel(ent_m, ent_w, rs2_e) : 2'b00;
    assign forward_ce = out_en ? e_sel(ent_m, ent_w, rs4_e) : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_int && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_d_int && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    // Counters absent in this build; no extra state.
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: three instances (default, LOAD_STALL_CYCLES=2, ZERO_REG_HARDWIRED=1) share stimulus.
module tb_hazard_scheduler;

    logic       clk;
    logic       rst;
    logic       valid_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rs4_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic       load_d;
    logic       branch_taken_e;
    logic       jump_e;

    logic       a_fad, a_fbd, a_fcd, a_sf, a_sd, a_fd, a_fe;
    logic [1:0] a_fae, a_fbe, a_fce, a_st;
    logic       b_fad, b_fbd, b_fcd, b_sf, b_sd, b_fd, b_fe;
    logic [1:0] b_fae, b_fbe, b_fce, b_st;
    logic       z_fad, z_fbd, z_fcd, z_sf, z_sd, z_fd, z_fe;
    logic [1:0] z_fae, z_fbe, z_fce, z_st;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt, z_scnt, z_fcnt;
`endif

    logic [3:0]  a_sb, b_sb;
    logic [14:0] a_all, b_all, z_all;
    assign a_sb  = {a_sf, a_sd, a_fe, a_fd};
    assign b_sb  = {b_sf, b_sd, b_fe, b_fd};
    assign a_all = {a_fad, a_fbd, a_fcd, a_fae, a_fbe, a_fce, a_sb, a_st};
    assign b_all = {b_fad, b_fbd, b_fcd, b_fae, b_fbe, b_fce, b_sb, b_st};
    assign z_all = {z_fad, z_fbd, z_fcd, z_fae, z_fbe, z_fce, z_sf, z_sd, z_fe, z_fd, z_st};

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scheduler dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs4_d(rs4_d),
        .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .branch_taken_e(branch_taken_e),
        .jump_e(jump_e), .ForwardAD(a_fad), .ForwardBD(a_fbd), .ForwardCD(a_fcd),
        .forward_ae(a_fae), .forward_be(a_fbe), .forward_ce(a_fce), .stall_f(a_sf),
        .stall_d(a_sd), .flush_d(a_fd), .flush_e(a_fe), .sched_state(a_st)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
    );

    hazard_scheduler #(.LOAD_STALL_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs4_d(rs4_d),
        .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .branch_taken_e(branch_taken_e),
        .jump_e(jump_e), .ForwardAD(b_fad), .ForwardBD(b_fbd), .ForwardCD(b_fcd),
        .forward_ae(b_fae), .forward_be(b_fbe), .forward_ce(b_fce), .stall_f(b_sf),
        .stall_d(b_sd), .flush_d(b_fd), .flush_e(b_fe), .sched_state(b_st)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
    );

    hazard_scheduler #(.ZERO_REG_HARDWIRED(1)) dutz (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs4_d(rs4_d),
        .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .branch_taken_e(branch_taken_e),
        .jump_e(jump_e), .ForwardAD(z_fad), .ForwardBD(z_fbd), .ForwardCD(z_fcd),
        .forward_ae(z_fae), .forward_be(z_fbe), .forward_ce(z_fce), .stall_f(z_sf),
        .stall_d(z_sd), .flush_d(z_fd), .flush_e(z_fe), .sched_state(z_st)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(z_scnt), .flush_cnt(z_fcnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (tests run %0d)", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] d, input logic rw, input logic ld);
        valid_d        = v;
        rs1_d          = a;
        rs2_d          = b;
        rs4_d          = c;
        rd_d           = d;
        regwrite_d     = rw;
        load_d         = ld;
        branch_taken_e = 1'b0;
        jump_e         = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            tick();
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        // Reset with random inputs: every output quiet.
        for (int i = 0; i < 4; i++) begin
            {valid_d, rs1_d, rs2_d, rs4_d, rd_d, regwrite_d, load_d, branch_taken_e, jump_e} = 25'($urandom);
            #3;
            check("rst_a", 32'(a_all), 32'd0);
            check("rst_b", 32'(b_all), 32'd0);
            check("rst_z", 32'(z_all), 32'd0);
            tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        check("rst_scnt", 32'(a_scnt), 32'd0);
        check("rst_fcnt", 32'(a_fcnt), 32'd0);
`endif
        idle();
        rst = 1'b1;
        #1;
        check("post_rst0", 32'(a_all), 32'd0);
        tick();
        check("post_rst1", 32'(a_all), 32'd0);
        tick();

        // W forwarding into D
        drive(1, 5'd1, 5'd2, 5'd0, 5'd5, 1, 0);    tick();
        drive(1, 5'd11, 5'd12, 5'd13, 5'd10, 1, 0); tick();
        drive(1, 5'd11, 5'd12, 5'd13, 5'd14, 1, 0); tick();
        drive(1, 5'd5, 5'd6, 5'd7, 5'd8, 1, 0);     #1;
        check("wf_ad", 32'(a_fad), 32'd1);
        check("wf_bd", 32'(a_fbd), 32'd0);
        check("wf_cd", 32'(a_fcd), 32'd0);
        check("wf_nostall", 32'(a_sb), 32'd0);
        tick();
        drive(1, 5'd0, 5'd10, 5'd10, 5'd15, 1, 0);  #1;
        check("wf2_abc", 32'({a_fad, a_fbd, a_fcd}), 32'b011);
        tick();
        idles(3);

        // E forwarding from M (adjacent) and from W (one apart)
        drive(1, 5'd1, 5'd2, 5'd3, 5'd7, 1, 0);    tick();
        drive(1, 5'd4, 5'd7, 5'd9, 5'd20, 1, 0);   tick();
        idle(); #1;
        check("ef_m", 32'({a_fae, a_fbe, a_fce}), 32'b00_10_00);
        tick();
        idles(1);
        drive(1, 5'd1, 5'd2, 5'd3, 5'd7, 1, 0);    tick();
        drive(1, 5'd22, 5'd23, 5'd24, 5'd21, 1, 0); tick();
        drive(1, 5'd4, 5'd7, 5'd9, 5'd20, 1, 0);   tick();
        idle(); #1;
        check("ef_w", 32'({a_fae, a_fbe, a_fce}), 32'b00_01_00);
        tick();
        // M wins over W when both write the same register
        drive(1, 5'd1, 5'd2, 5'd3, 5'd9, 1, 0);    tick();
        drive(1, 5'd1, 5'd2, 5'd3, 5'd9, 1, 0);    tick();
        drive(1, 5'd9, 5'd0, 5'd9, 5'd11, 1, 0);   tick();
        idle(); #1;
        check("ef_prio", 32'({a_fae, a_fbe, a_fce}), 32'b10_00_10);
        tick();
        idles(3);

        // Load-use with one bubble, twice back to back
        for (int k = 0; k < 2; k++) begin
            drive(1, 5'd1, 5'd0, 5'd0, 5'd3, 1, 1); #1;
            check("lu_pre", 32'(a_sb), 32'd0);
            tick();
            drive(1, 5'd3, 5'd4, 5'd5, 5'd6, 1, 0); #1;
            check("lu_stall", 32'(a_sb), 32'b1110);
            check("lu_state", 32'(a_st), 32'd0);
            tick();
            #1;
            check("lu_rel", 32'(a_sb), 32'b0000);
            check("lu_mload", 32'(a_fae), 32'b00);
            tick();
            idle(); #1;
            check("lu_fwd", 32'(a_fae), 32'b01);
            tick();
        end

        // Load-use with two bubbles
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd0, 5'd3, 1, 1); tick();
        drive(1, 5'd3, 5'd4, 5'd5, 5'd6, 1, 0); #1;
        check("l2_c1", 32'({b_sb, b_st}), 32'b1110_00);
        tick(); #1;
        check("l2_c2", 32'({b_sb, b_st}), 32'b1110_01);
        tick(); #1;
        check("l2_c3", 32'({b_sb, b_st}), 32'b0000_00);
        check("l2_fad", 32'(b_fad), 32'd1);
        tick();
        idle(); #1;
        check("l2_c4", 32'(b_sb), 32'd0);
        tick();
        idles(3);

        // Flush beats a same-cycle load-use detect
        drive(1, 5'd1, 5'd0, 5'd0, 5'd3, 1, 1); tick();
        drive(1, 5'd3, 5'd4, 5'd5, 5'd6, 1, 0); branch_taken_e = 1'b1; #1;
        check("fp_a", 32'(a_sb), 32'b0011);
        check("fp_b", 32'(b_sb), 32'b0011);
        tick();
        idle(); #1;
        check("fp_after", 32'({a_sb, a_st}), 32'd0);
        tick();
        idles(3);

        // Jump abandons an LSTALL in progress
        drive(1, 5'd1, 5'd0, 5'd0, 5'd3, 1, 1); tick();
        drive(1, 5'd3, 5'd4, 5'd5, 5'd6, 1, 0); #1;
        check("ab_stall", 32'(b_sb), 32'b1110);
        tick();
        jump_e = 1'b1; #1;
        check("ab_flush", 32'({b_sb, b_st}), 32'b0011_01);
        tick();
        idle(); #1;
        check("ab_after", 32'({b_sb, b_st}), 32'd0);
        tick();
        idles(3);

        // Reset asserted in the middle of LSTALL
        drive(1, 5'd1, 5'd0, 5'd0, 5'd3, 1, 1); tick();
        drive(1, 5'd3, 5'd4, 5'd5, 5'd6, 1, 0); tick();
        #1;
        check("rm_in", 32'(b_st), 32'd1);
        rst = 1'b0; #1;
        check("rm_rst", 32'(b_all), 32'd0);
        tick();
        rst = 1'b1;
        idle(); #1;
        check("rm_rel", 32'(b_all), 32'd0);
        tick(); #1;
        check("rm_after", 32'(b_all), 32'd0);
        tick();

        // Register 0 hardwired vs ordinary
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd3, 5'd0, 1, 1); tick();
        drive(1, 5'd0, 5'd0, 5'd0, 5'd6, 1, 0); #1;
        check("z_nostall", 32'(z_sd), 32'd0);
        check("z_ref_stall", 32'(a_sd), 32'd1);
        tick();
        idle(); tick();
        drive(1, 5'd0, 5'd0, 5'd0, 5'd7, 1, 0); #1;
        check("z_nofwd_d", 32'({z_fad, z_fbd, z_fcd}), 32'd0);
        check("z_ref_fwd_d", 32'(a_fad), 32'd1);
        tick();
        drive(1, 5'd1, 5'd2, 5'd3, 5'd0, 1, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd0, 5'd8, 1, 0); tick();
        idle(); #1;
        check("z_nofwd_e", 32'({z_fae, z_fbe, z_fce}), 32'd0);
        check("z_ref_fwd_e", 32'({a_fae, a_fbe, a_fce}), 32'b10_10_10);
        tick();

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd1, 5'd0, 5'd0, 5'd3, 1, 1); tick();
            drive(1, 5'd3, 5'd4, 5'd5, 5'd6, 1, 0); tick();
            tick();
            idle(); tick();
        end
        for (int k = 0; k < 2; k++) begin
            idle(); branch_taken_e = 1'b1; tick();
        end
        idle(); #1;
        check("pc_stall", 32'(a_scnt), 32'd3);
        check("pc_flush", 32'(a_fcnt), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
